// File: rtl/adc_sar_pkg.sv
// rtl/adc_sar_pkg.sv - shared state encoding and default field widths for the SAR controller
package adc_sar_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_SET,
        ST_WAIT,
        ST_DECIDE,
        ST_DONE
    } sar_state_e;

    localparam int DEF_ROW_BITS      = 4;
    localparam int DEF_COL_BITS      = 5;
    localparam int DEF_BIN_BITS      = 3;
    localparam int DEF_SAMPLE_CYCLES = 2;
    localparam int DEF_SETTLE_CYCLES = 1;

endpackage

// File: rtl/adc_therm_decoder.sv
// rtl/adc_therm_decoder.sv - combinational trial code to thermometer row/column and binary cap map
import adc_sar_pkg::*;

module adc_therm_decoder #(
    parameter int ROW_BITS = DEF_ROW_BITS,
    parameter int COL_BITS = DEF_COL_BITS,
    parameter int BIN_BITS = DEF_BIN_BITS,
    localparam int ROWS    = 1 << ROW_BITS,
    localparam int COLS    = 1 << COL_BITS,
    localparam int N       = ROW_BITS + COL_BITS + BIN_BITS
) (
    input  logic [N-1:0]        code,
    output logic [ROWS-1:0]     row,
    output logic [ROWS-1:0]     rowon,
    output logic [COLS-1:0]     col,
    output logic [BIN_BITS-1:0] bincap
);

    logic [ROW_BITS-1:0] row_f;
    logic [COL_BITS-1:0] col_f;

    assign row_f  = code[N-1 -: ROW_BITS];
    assign col_f  = code[BIN_BITS +: COL_BITS];
    assign bincap = code[BIN_BITS-1:0];
    assign rowon  = row >> 1;

    always_comb begin
        row = '0;
        for (int j = 0; j < ROWS; j++) begin
            row[j] = (int'(row_f) >= j);
        end
    end

    // Serpentine fill: odd rows grow from the top column downwards.
    always_comb begin
        col = '0;
        for (int i = 0; i < COLS; i++) begin
            if (row_f[0]) begin
                col[i] = (int'(col_f) >= (COLS - 1 - i));
            end else begin
                col[i] = (int'(col_f) >= i);
            end
        end
    end

endmodule

// File: rtl/adc_sar_therm_ctrl.sv
// rtl/adc_sar_therm_ctrl.sv - SAR bit-search controller driving a split thermometer/binary cap DAC
import adc_sar_pkg::*;

module adc_sar_therm_ctrl #(
    parameter int ROW_BITS      = DEF_ROW_BITS,
    parameter int COL_BITS      = DEF_COL_BITS,
    parameter int BIN_BITS      = DEF_BIN_BITS,
    parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    localparam int ROWS         = 1 << ROW_BITS,
    localparam int COLS         = 1 << COL_BITS,
    localparam int N            = ROW_BITS + COL_BITS + BIN_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                cont_i,
    input  logic                comp_i,
    output logic                busy_o,
    output logic                sample_o,
    output logic                comp_en_o,
    output logic [N-1:0]        result_o,
    output logic                valid_o,
    output logic [ROWS-1:0]     row_n,
    output logic [ROWS-1:0]     rowon_n,
    output logic [COLS-1:0]     col_n,
    output logic [BIN_BITS-1:0] bincap_n
);

    localparam int KW = (N > 1) ? $clog2(N) : 1;

    sar_state_e    state;
    logic [N-1:0]  trial;
    logic [KW-1:0] k_idx;
    logic [15:0]   cnt;

    logic [ROWS-1:0]     dec_row;
    logic [ROWS-1:0]     dec_rowon;
    logic [COLS-1:0]     dec_col;
    logic [BIN_BITS-1:0] dec_bin;

    adc_therm_decoder #(
        .ROW_BITS (ROW_BITS),
        .COL_BITS (COL_BITS),
        .BIN_BITS (BIN_BITS)
    ) u_decoder (
        .code   (trial),
        .row    (dec_row),
        .rowon  (dec_rowon),
        .col    (dec_col),
        .bincap (dec_bin)
    );

    // Status outputs are registered alongside the state so they line up with it exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            trial     <= '0;
            k_idx     <= '0;
            cnt       <= '0;
            result_o  <= '0;
            valid_o   <= 1'b0;
            busy_o    <= 1'b0;
            sample_o  <= 1'b0;
            comp_en_o <= 1'b0;
        end else begin
            valid_o   <= 1'b0;
            comp_en_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    trial <= '0;
                    if (start_i) begin
                        state    <= ST_SAMPLE;
                        cnt      <= '0;
                        busy_o   <= 1'b1;
                        sample_o <= 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    if (cnt == 16'(SAMPLE_CYCLES - 1)) begin
                        state    <= ST_SET;
                        sample_o <= 1'b0;
                        k_idx    <= KW'(N - 1);
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_SET: begin
                    trial[k_idx] <= 1'b1;
                    cnt          <= '0;
                    if (SETTLE_CYCLES == 0) begin
                        state     <= ST_DECIDE;
                        comp_en_o <= 1'b1;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 16'(SETTLE_CYCLES - 1)) begin
                        state     <= ST_DECIDE;
                        comp_en_o <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_DECIDE: begin
                    if (!comp_i) begin
                        trial[k_idx] <= 1'b0;
                    end
                    if (k_idx == '0) begin
                        state <= ST_DONE;
                    end else begin
                        k_idx <= k_idx - KW'(1);
                        state <= ST_SET;
                    end
                end
                ST_DONE: begin
                    result_o <= trial;
                    valid_o  <= 1'b1;
                    trial    <= '0;
                    cnt      <= '0;
                    if (cont_i) begin
                        state    <= ST_SAMPLE;
                        sample_o <= 1'b1;
                    end else begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    trial     <= '0;
                    busy_o    <= 1'b0;
                    sample_o  <= 1'b0;
                end
            endcase
        end
    end

    // Drive registers hold decode(0) in reset: lowest row and column active, no bin caps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_n    <= {{(ROWS-1){1'b1}}, 1'b0};
            rowon_n  <= '1;
            col_n    <= {{(COLS-1){1'b1}}, 1'b0};
            bincap_n <= '1;
        end else begin
            row_n    <= ~dec_row;
            rowon_n  <= ~dec_rowon;
            col_n    <= ~dec_col;
            bincap_n <= ~dec_bin;
        end
    end

endmodule
